alu_scheduler: RTL and testbench

Shares the single 64-bit-result integer/FPU ALU between up to four requesters (CORDIC iteration engine, address/shift unit, host register port, debug port). It arbitrates round-robin, registers operands and op code into the ALU, waits a per-op-class multicycle latency, captures result and V/C/Z/N flags, and returns them with the requester ID over a valid/ready response channel. One operation is in flight at a time.

---
 rtl/alu_scheduler_if.sv | 27 ++
 rtl/alu_scheduler.sv | 183 ++++++++++++++++++
 tb/tb_alu_scheduler.sv | 306 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/alu_scheduler_if.sv
// Request/response bundle between the ALU requesters and alu_scheduler.
// Operand and op-code fields are packed per requester, requester i in the i-th slice.
interface alu_scheduler_if #(
    parameter int NUM_REQ = 4
);
    logic [NUM_REQ-1:0]    req_valid;
    logic [NUM_REQ-1:0]    req_ready;
    logic [NUM_REQ*32-1:0] req_a;
    logic [NUM_REQ*32-1:0] req_b;
    logic [NUM_REQ*5-1:0]  req_op;
    logic                  rsp_valid;
    logic                  rsp_ready;
    logic [1:0]            rsp_id;
    logic [63:0]           rsp_result;
    logic [3:0]            rsp_flags;
    logic                  rsp_err;

    modport master (
        output req_valid, req_a, req_b, req_op, rsp_ready,
        input  req_ready, rsp_valid, rsp_id, rsp_result, rsp_flags, rsp_err
    );

    modport slave (
        input  req_valid, req_a, req_b, req_op, rsp_ready,
        output req_ready, rsp_valid, rsp_id, rsp_result, rsp_flags, rsp_err
    );
endinterface

// File: rtl/alu_scheduler.sv
// Round-robin scheduler sharing one multicycle ALU between up to four requesters;
// one operation in flight, result and flags returned over a valid/ready channel.
module alu_scheduler #(
    parameter int NUM_REQ   = 4,
    parameter int LAT_LOGIC = 1,
    parameter int LAT_MUL   = 2,
    parameter int LAT_FPU   = 3
) (
    input  logic           clk,
    input  logic           rst_n,
    alu_scheduler_if.slave bus,
    output logic [31:0]    alu_a,
    output logic [31:0]    alu_b,
    output logic [4:0]     alu_ctrl,
    input  logic [63:0]    alu_result,
    input  logic           alu_v,
    input  logic           alu_c,
    input  logic           alu_z,
    input  logic           alu_n
);
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_EXEC = 2'd1,
        ST_RESP = 2'd2
    } state_t;

    state_t      state_r;
    state_t      state_nxt_s;
    logic [1:0]  rr_ptr_r;
    logic [1:0]  grant_id_s;
    logic        grant_valid_s;
    logic        accept_s;
    logic        legal_s;
    int          best_off_s;
    logic [4:0]  op_arr_s [NUM_REQ];
    logic [31:0] a_arr_s  [NUM_REQ];
    logic [31:0] b_arr_s  [NUM_REQ];
    logic [4:0]  grant_op_s;
    logic [7:0]  cnt_r;
    logic [1:0]  rsp_id_r;
    logic [63:0] rsp_result_r;
    logic [3:0]  rsp_flags_r;
    logic        rsp_err_r;
    logic [31:0] alu_a_r;
    logic [31:0] alu_b_r;
    logic [4:0]  alu_ctrl_r;

    function automatic logic op_legal(input logic [4:0] op);
        case (op)
            5'b00000, 5'b00001, 5'b00010, 5'b00011,
            5'b00100, 5'b00101, 5'b00110, 5'b00111,
            5'b10000, 5'b10001: op_legal = 1'b1;
            default:            op_legal = 1'b0;
        endcase
    endfunction

    function automatic logic [7:0] op_latency(input logic [4:0] op);
        case (op)
            5'b00010:           op_latency = 8'(LAT_MUL);
            5'b10000, 5'b10001: op_latency = 8'(LAT_FPU);
            default:            op_latency = 8'(LAT_LOGIC);
        endcase
    endfunction

    // Split the packed request buses into per-requester fields.
    always_comb begin
        for (int j = 0; j < NUM_REQ; j++) begin
            op_arr_s[j] = bus.req_op[5*j +: 5];
            a_arr_s[j]  = bus.req_a[32*j +: 32];
            b_arr_s[j]  = bus.req_b[32*j +: 32];
        end
    end

    // Round-robin pick: the valid requester closest above rr_ptr (modulo NUM_REQ) wins.
    always_comb begin
        best_off_s = NUM_REQ;
        grant_id_s = 2'd0;
        for (int j = 0; j < NUM_REQ; j++) begin
            if (bus.req_valid[j] && (((j + NUM_REQ - int'(rr_ptr_r)) % NUM_REQ) < best_off_s)) begin
                best_off_s = (j + NUM_REQ - int'(rr_ptr_r)) % NUM_REQ;
                grant_id_s = 2'(j);
            end else begin
                grant_id_s = grant_id_s;
            end
        end
        grant_valid_s = (best_off_s < NUM_REQ);
        grant_op_s    = op_arr_s[grant_id_s];
        legal_s       = op_legal(grant_op_s);
    end

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // Next-state logic; illegal ops skip EXEC and answer straight away.
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (accept_s) state_nxt_s = legal_s ? ST_EXEC : ST_RESP;
                else          state_nxt_s = ST_IDLE;
            end
            ST_EXEC: begin
                if (cnt_r == 8'd1) state_nxt_s = ST_RESP;
                else               state_nxt_s = ST_EXEC;
            end
            ST_RESP: begin
                if (bus.rsp_ready) state_nxt_s = ST_IDLE;
                else               state_nxt_s = ST_RESP;
            end
            default: state_nxt_s = ST_IDLE;
        endcase
    end

    // Outputs decoded from state: grants are offered only while idle.
    always_comb begin
        accept_s = (state_r == ST_IDLE) && grant_valid_s;
        if (accept_s) begin
            bus.req_ready = {{(NUM_REQ-1){1'b0}}, 1'b1} << grant_id_s;
        end else begin
            bus.req_ready = '0;
        end
        bus.rsp_valid = (state_r == ST_RESP);
    end

    // Datapath: operand load on accept, latency countdown, result capture.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rr_ptr_r     <= 2'd0;
            cnt_r        <= 8'd0;
            rsp_id_r     <= 2'd0;
            rsp_result_r <= 64'd0;
            rsp_flags_r  <= 4'd0;
            rsp_err_r    <= 1'b0;
            alu_a_r      <= 32'd0;
            alu_b_r      <= 32'd0;
            alu_ctrl_r   <= 5'd0;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (accept_s) begin
                        rr_ptr_r <= 2'((int'(grant_id_s) + 1) % NUM_REQ);
                        rsp_id_r <= grant_id_s;
                        if (legal_s) begin
                            alu_a_r    <= a_arr_s[grant_id_s];
                            alu_b_r    <= b_arr_s[grant_id_s];
                            alu_ctrl_r <= grant_op_s;
                            cnt_r      <= op_latency(grant_op_s);
                        end else begin
                            rsp_err_r    <= 1'b1;
                            rsp_result_r <= 64'd0;
                            rsp_flags_r  <= 4'd0;
                        end
                    end
                end
                ST_EXEC: begin
                    cnt_r <= cnt_r - 8'd1;
                    if (cnt_r == 8'd1) begin
                        rsp_result_r <= alu_result;
                        rsp_flags_r  <= {alu_v, alu_c, alu_z, alu_n};
                        rsp_err_r    <= 1'b0;
                    end
                end
                default: begin
                    cnt_r <= cnt_r;
                end
            endcase
        end
    end

    assign bus.rsp_id     = rsp_id_r;
    assign bus.rsp_result = rsp_result_r;
    assign bus.rsp_flags  = rsp_flags_r;
    assign bus.rsp_err    = rsp_err_r;
    assign alu_a          = alu_a_r;
    assign alu_b          = alu_b_r;
    assign alu_ctrl       = alu_ctrl_r;
endmodule

// File: tb/tb_alu_scheduler.sv
// Directed bench for alu_scheduler: vector table for single operations plus
// hand sequences for round-robin, backpressure, illegal op and mid-op reset.
module tb_alu_scheduler;
    logic        clk;
    logic        rst_n;
    logic [3:0]  tv;
    logic [31:0] ta [4];
    logic [31:0] tb_b [4];
    logic [4:0]  top [4];
    logic        rdy;
    logic [31:0] alu_a, alu_b;
    logic [4:0]  alu_ctrl;
    logic [63:0] alu_result;
    logic        alu_v, alu_c, alu_z, alu_n;
    int          n_cmp, n_bad;

    typedef struct {
        logic [1:0]  id;
        logic [31:0] a;
        logic [31:0] b;
        logic [4:0]  op;
        int          wt;
        logic [63:0] res;
        logic [3:0]  fl;
        logic        err;
    } vec_t;

    vec_t vt [13];
    int   rr_exp [6];

    alu_scheduler_if #(.NUM_REQ(4)) bus ();

    assign bus.req_valid = tv;
    assign bus.req_a     = {ta[3], ta[2], ta[1], ta[0]};
    assign bus.req_b     = {tb_b[3], tb_b[2], tb_b[1], tb_b[0]};
    assign bus.req_op    = {top[3], top[2], top[1], top[0]};
    assign bus.rsp_ready = rdy;

    alu_scheduler #(.NUM_REQ(4), .LAT_LOGIC(1), .LAT_MUL(2), .LAT_FPU(3)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .bus        (bus),
        .alu_a      (alu_a),
        .alu_b      (alu_b),
        .alu_ctrl   (alu_ctrl),
        .alu_result (alu_result),
        .alu_v      (alu_v),
        .alu_c      (alu_c),
        .alu_z      (alu_z),
        .alu_n      (alu_n)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Reference ALU; the "FPU" ops are stand-ins that concatenate the operands.
    always_comb begin
        logic [32:0] s;
        logic [63:0] r;
        s = 33'd0;
        r = 64'd0;
        alu_v = 1'b0;
        alu_c = 1'b0;
        case (alu_ctrl)
            5'b00000: begin
                s = {1'b0, alu_a} + {1'b0, alu_b};
                r = {32'd0, s[31:0]};
                alu_c = s[32];
                alu_v = (alu_a[31] == alu_b[31]) && (s[31] != alu_a[31]);
            end
            5'b00001: begin
                s = {1'b0, alu_a} - {1'b0, alu_b};
                r = {32'd0, s[31:0]};
                alu_c = (alu_a < alu_b);
                alu_v = (alu_a[31] != alu_b[31]) && (s[31] != alu_a[31]);
            end
            5'b00010: r = {32'd0, alu_a} * {32'd0, alu_b};
            5'b00011: r = {32'd0, alu_a & alu_b};
            5'b00100: r = {32'd0, alu_a | alu_b};
            5'b00101: r = {32'd0, alu_a ^ alu_b};
            5'b00110: r = {32'd0, alu_a >> alu_b[4:0]};
            5'b00111: r = {32'd0, alu_a << alu_b[4:0]};
            5'b10000: r = {alu_a, alu_b};
            5'b10001: r = {alu_b, alu_a};
            default:  r = 64'd0;
        endcase
        alu_result = r;
        alu_z = (r == 64'd0);
        alu_n = r[63];
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Raise a request at a negedge, wait (bounded) for its grant, drop it after the accept edge.
    task automatic issue(input logic [1:0] id, input logic [31:0] a, input logic [31:0] b,
                         input logic [4:0] op);
        int n;
        ta[id] = a;
        tb_b[id] = b;
        top[id] = op;
        tv[id] = 1'b1;
        n = 0;
        #1;
        while (bus.req_ready[id] !== 1'b1 && n < 20) begin
            @(negedge clk);
            #1;
            n++;
        end
        check("accept_timeout", 64'(n < 20), 64'd1);
        @(posedge clk);
        @(negedge clk);
        tv[id] = 1'b0;
    endtask

    // Count clock edges from the accept point until rsp_valid, giving up after 20.
    task automatic wait_rsp(output int k);
        k = 0;
        while (bus.rsp_valid !== 1'b1 && k < 20) begin
            @(posedge clk);
            @(negedge clk);
            k++;
        end
    endtask

    initial begin
        int k, cyc, nacc, last, seen;
        n_cmp = 0;
        n_bad = 0;
        rst_n = 1'b0;
        rdy = 1'b1;
        tv = 4'd0;
        for (int j = 0; j < 4; j++) begin
            ta[j] = 32'd0;
            tb_b[j] = 32'd0;
            top[j] = 5'd0;
        end

        vt[0]  = '{2'd0, 32'h0000_0005, 32'h0000_0003, 5'b00000, 1, 64'h0000_0000_0000_0008, 4'b0000, 1'b0};
        vt[1]  = '{2'd2, 32'hFFFF_FFFF, 32'h0000_0002, 5'b00010, 2, 64'h0000_0001_FFFF_FFFE, 4'b0000, 1'b0};
        vt[2]  = '{2'd1, 32'hFFFF_FFFF, 32'h0000_0001, 5'b00000, 1, 64'h0000_0000_0000_0000, 4'b0110, 1'b0};
        vt[3]  = '{2'd3, 32'h7FFF_FFFF, 32'h0000_0001, 5'b00000, 1, 64'h0000_0000_8000_0000, 4'b1000, 1'b0};
        vt[4]  = '{2'd0, 32'h0000_0003, 32'h0000_0005, 5'b00001, 1, 64'h0000_0000_FFFF_FFFE, 4'b0100, 1'b0};
        vt[5]  = '{2'd1, 32'hA5A5_A5A5, 32'hFFFF_0000, 5'b00101, 1, 64'h0000_0000_5A5A_A5A5, 4'b0000, 1'b0};
        vt[6]  = '{2'd2, 32'h0000_0001, 32'h0000_001F, 5'b00111, 1, 64'h0000_0000_8000_0000, 4'b0000, 1'b0};
        vt[7]  = '{2'd3, 32'h8000_0000, 32'h0000_0001, 5'b10000, 3, 64'h8000_0000_0000_0001, 4'b0001, 1'b0};
        vt[8]  = '{2'd0, 32'h8000_0000, 32'h0000_0004, 5'b00110, 1, 64'h0000_0000_0800_0000, 4'b0000, 1'b0};
        vt[9]  = '{2'd1, 32'h1234_5678, 32'h0000_0001, 5'b11111, 0, 64'h0000_0000_0000_0000, 4'b0000, 1'b1};
        vt[10] = '{2'd2, 32'hF0F0_F0F0, 32'h0FF0_0FF0, 5'b00011, 1, 64'h0000_0000_00F0_00F0, 4'b0000, 1'b0};
        vt[11] = '{2'd3, 32'h1234_5678, 32'h9ABC_DEF0, 5'b10001, 3, 64'h9ABC_DEF0_1234_5678, 4'b0001, 1'b0};
        vt[12] = '{2'd0, 32'h0001_0000, 32'h0001_0000, 5'b00010, 2, 64'h0000_0001_0000_0000, 4'b0000, 1'b0};
        rr_exp = '{0, 1, 2, 3, 0, 1};

        // Reset state
        #12;
        check("rst_req_ready", 64'(bus.req_ready), 64'd0);
        check("rst_rsp_valid", 64'(bus.rsp_valid), 64'd0);
        check("rst_rsp_id", 64'(bus.rsp_id), 64'd0);
        check("rst_rsp_result", bus.rsp_result, 64'd0);
        check("rst_rsp_flags", 64'(bus.rsp_flags), 64'd0);
        check("rst_rsp_err", 64'(bus.rsp_err), 64'd0);
        check("rst_alu_a", 64'(alu_a), 64'd0);
        check("rst_alu_b", 64'(alu_b), 64'd0);
        check("rst_alu_ctrl", 64'(alu_ctrl), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;

        // Single operations from the table
        for (int i = 0; i < 13; i++) begin
            issue(vt[i].id, vt[i].a, vt[i].b, vt[i].op);
            if (!vt[i].err) begin
                check("tbl_alu_a", 64'(alu_a), 64'(vt[i].a));
                check("tbl_alu_b", 64'(alu_b), 64'(vt[i].b));
                check("tbl_alu_ctrl", 64'(alu_ctrl), 64'(vt[i].op));
            end
            wait_rsp(k);
            check("tbl_latency", 64'(k), 64'(vt[i].wt));
            check("tbl_rsp_id", 64'(bus.rsp_id), 64'(vt[i].id));
            check("tbl_rsp_result", bus.rsp_result, vt[i].res);
            check("tbl_rsp_flags", 64'(bus.rsp_flags), 64'(vt[i].fl));
            check("tbl_rsp_err", 64'(bus.rsp_err), 64'(vt[i].err));
            @(posedge clk);
            @(negedge clk);
        end

        // Round-robin with all four requesters continuously valid
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        for (int j = 0; j < 4; j++) begin
            ta[j] = 32'h0000_00FF;
            tb_b[j] = 32'(j + 1);
            top[j] = 5'b00011;
        end
        tv = 4'hF;
        cyc = 0;
        nacc = 0;
        last = 0;
        while (nacc < 6 && cyc < 60) begin
            #1;
            check("rr_onehot", 64'($countones(bus.req_ready) <= 1), 64'd1);
            if (bus.req_ready != 4'd0) begin
                check("rr_order", 64'(bus.req_ready), 64'(4'b0001 << rr_exp[nacc]));
                if (nacc > 0) check("rr_gap", 64'(cyc - last), 64'd3);
                last = cyc;
                nacc++;
            end
            @(negedge clk);
            cyc++;
        end
        tv = 4'h0;
        check("rr_count", 64'(nacc), 64'd6);
        wait_rsp(k);
        check("rr_last_id", 64'(bus.rsp_id), 64'd1);
        @(posedge clk);
        @(negedge clk);

        // Backpressure on an fadd while another requester waits
        rdy = 1'b0;
        issue(2'd1, 32'h0000_0001, 32'h0000_0002, 5'b10000);
        ta[0] = 32'h0000_0011;
        tb_b[0] = 32'h0000_0022;
        top[0] = 5'b00000;
        tv[0] = 1'b1;
        wait_rsp(k);
        check("bp_latency", 64'(k), 64'd3);
        for (int c = 0; c < 10; c++) begin
            check("bp_valid", 64'(bus.rsp_valid), 64'd1);
            check("bp_result", bus.rsp_result, 64'h0000_0001_0000_0002);
            check("bp_id", 64'(bus.rsp_id), 64'd1);
            check("bp_req_ready", 64'(bus.req_ready), 64'd0);
            @(negedge clk);
        end
        rdy = 1'b1;
        #1;
        check("bp_hs_no_grant", 64'(bus.req_ready), 64'd0);
        @(posedge clk);
        @(negedge clk);
        check("bp_next_grant", 64'(bus.req_ready), 64'b0001);
        @(posedge clk);
        @(negedge clk);
        tv[0] = 1'b0;
        wait_rsp(k);
        check("bp2_latency", 64'(k), 64'd1);
        check("bp2_result", bus.rsp_result, 64'h0000_0000_0000_0033);
        check("bp2_id", 64'(bus.rsp_id), 64'd0);
        @(posedge clk);
        @(negedge clk);

        // Illegal op leaves the ALU registers alone
        issue(2'd3, 32'h0000_DEAD, 32'h0000_BEEF, 5'b01010);
        check("ill_valid", 64'(bus.rsp_valid), 64'd1);
        check("ill_err", 64'(bus.rsp_err), 64'd1);
        check("ill_id", 64'(bus.rsp_id), 64'd3);
        check("ill_result", bus.rsp_result, 64'd0);
        check("ill_flags", 64'(bus.rsp_flags), 64'd0);
        check("ill_alu_ctrl", 64'(alu_ctrl), 64'd0);
        check("ill_alu_a", 64'(alu_a), 64'h11);
        check("ill_alu_b", 64'(alu_b), 64'h22);
        @(posedge clk);
        @(negedge clk);

        // Reset during EXEC of an fsub
        issue(2'd2, 32'h0000_0040, 32'h0000_0002, 5'b10001);
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("mid_rst_valid", 64'(bus.rsp_valid), 64'd0);
        check("mid_rst_id", 64'(bus.rsp_id), 64'd0);
        check("mid_rst_alu_a", 64'(alu_a), 64'd0);
        check("mid_rst_alu_ctrl", 64'(alu_ctrl), 64'd0);
        check("mid_rst_err", 64'(bus.rsp_err), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        seen = 0;
        for (int c = 0; c < 8; c++) begin
            @(negedge clk);
            if (bus.rsp_valid) seen = 1;
        end
        check("mid_rst_no_rsp", 64'(seen), 64'd0);
        top[0] = 5'b00000;
        top[3] = 5'b00000;
        tv = 4'b1001;
        #1;
        check("mid_rst_rr_ptr", 64'(bus.req_ready), 64'b0001);
        tv = 4'b0000;
        issue(2'd0, 32'h0000_0002, 32'h0000_0002, 5'b00000);
        wait_rsp(k);
        check("post_rst_latency", 64'(k), 64'd1);
        check("post_rst_result", bus.rsp_result, 64'd4);
        check("post_rst_id", 64'(bus.rsp_id), 64'd0);
        @(posedge clk);
        @(negedge clk);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
